// File: rtl/multicycle_sequencer_pkg.sv
// Shared types and constants for the miniRV multi-cycle sequencer:
// state encodings, memory-op opcodes and the memory-op classifier.
package multicycle_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd7
   } seq_state_e;

   localparam logic [6:0] OPC_LW = 7'b0000011;
   localparam logic [6:0] OPC_SW = 7'b0100011;

   function automatic logic is_mem_op(input logic [31:0] instr);
      return (instr[6:0] == OPC_LW) || (instr[6:0] == OPC_SW);
   endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// IROM and DRAM request/acknowledge bundle between the sequencer (master)
// and the memory side (slave).
interface multicycle_sequencer_if;

   logic        irom_req;
   logic        irom_ack;
   logic [31:0] irom_rdata;
   logic        dram_req;
   logic        dram_we;
   logic        dram_ack;

   modport master (
      output irom_req,
      output dram_req,
      output dram_we,
      input  irom_ack,
      input  irom_rdata,
      input  dram_ack
   );

   modport slave (
      input  irom_req,
      input  dram_req,
      input  dram_we,
      output irom_ack,
      output irom_rdata,
      output dram_ack
   );

endinterface

// File: rtl/multicycle_sequencer_bus_wait_timer.sv
// Counts consecutive un-acknowledged request cycles; expired flags the cycle
// that would be the limit'th wait (a zero limit never expires).
module multicycle_sequencer_bus_wait_timer #(
   parameter int TO_W = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clear,
   input  logic            count_en,
   input  logic [TO_W-1:0] limit,
   output logic            expired
);

   logic [TO_W-1:0] cnt_q;
   logic [TO_W-1:0] cnt_d;

   // Next wait count: clear wins over counting.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = {TO_W{1'b0}};
      end else if (count_en) begin
         cnt_d = cnt_q + TO_W'(1'b1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Wait counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= {TO_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // An ack in the limit cycle drops count_en, so the ack wins.
   assign expired = count_en && (limit != {TO_W{1'b0}})
                    && (cnt_q == (limit - TO_W'(1'b1)));

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the miniRV core: drives the
// IROM/DRAM handshakes, holds the instruction register and gates the WB strobes.
module multicycle_sequencer
   import multicycle_sequencer_pkg::*;
#(
   parameter int TIMEOUT_CYC = 255,
   parameter int TO_W        = 8,
   parameter int RET_W       = 32
) (
   input  logic                   cpu_clk,
   input  logic                   cpu_rst,
   input  logic                   halt,
   multicycle_sequencer_if.master bus,
   output logic [31:0]            inst,
   input  logic                   dec_rf_we,
   input  logic                   dec_data_we,
   output logic                   rf_we,
   output logic                   pc_we,
   output logic                   trap,
   output logic [2:0]             state_dbg,
   output logic [RET_W-1:0]       retire_cnt
);

   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYC);

   seq_state_e       state_q;
   seq_state_e       state_d;
   logic [31:0]      inst_q;
   logic [31:0]      inst_d;
   logic [RET_W-1:0] retire_q;
   logic [RET_W-1:0] retire_d;
   logic             trap_q;
   logic             trap_d;
   logic             irom_pend_q;
   logic             irom_pend_d;

   logic             irom_req_s;
   logic             dram_req_s;
   logic             wait_ack_s;
   logic             timer_clear_s;
   logic             timer_en_s;
   logic             expired_s;

   // Request decode from state; halt only gates a fetch not yet issued.
   always_comb begin
      irom_req_s = 1'b0;
      dram_req_s = 1'b0;
      if (!cpu_rst) begin
         case (state_q)
            ST_FETCH: irom_req_s = irom_pend_q | ~halt;
            ST_MEM:   dram_req_s = 1'b1;
            default: begin
               irom_req_s = 1'b0;
               dram_req_s = 1'b0;
            end
         endcase
      end else begin
         irom_req_s = 1'b0;
         dram_req_s = 1'b0;
      end
   end

   assign wait_ack_s    = (irom_req_s & bus.irom_ack) | (dram_req_s & bus.dram_ack);
   assign timer_en_s    = (irom_req_s | dram_req_s) & ~wait_ack_s;
   assign timer_clear_s = cpu_rst | ~timer_en_s;

   multicycle_sequencer_bus_wait_timer #(
      .TO_W (TO_W)
   ) u_wait_timer (
      .clk      (cpu_clk),
      .rst      (cpu_rst),
      .clear    (timer_clear_s),
      .count_en (timer_en_s),
      .limit    (TO_LIMIT),
      .expired  (expired_s)
   );

   // Next-state, instruction latch, retire count and sticky trap.
   always_comb begin
      state_d     = state_q;
      inst_d      = inst_q;
      retire_d    = retire_q;
      irom_pend_d = 1'b0;
      case (state_q)
         ST_FETCH: begin
            irom_pend_d = irom_req_s & ~bus.irom_ack;
            if (expired_s) begin
               state_d = ST_TRAP;
            end else if (irom_req_s && bus.irom_ack) begin
               state_d = ST_DECODE;
               inst_d  = bus.irom_rdata;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_DECODE: state_d = ST_EXEC;
         ST_EXEC: begin
            if (is_mem_op(inst_q)) begin
               state_d = ST_MEM;
            end else begin
               state_d = ST_WB;
            end
         end
         ST_MEM: begin
            if (expired_s) begin
               state_d = ST_TRAP;
            end else if (dram_req_s && bus.dram_ack) begin
               state_d = ST_WB;
            end else begin
               state_d = ST_MEM;
            end
         end
         ST_WB: begin
            state_d  = ST_FETCH;
            retire_d = retire_q + RET_W'(1'b1);
         end
         ST_TRAP: state_d = ST_TRAP;
         default: state_d = ST_TRAP;
      endcase
      trap_d = trap_q | (state_d == ST_TRAP);
   end

   // Sequencer state registers.
   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         state_q     <= ST_FETCH;
         inst_q      <= 32'h0000_0000;
         retire_q    <= {RET_W{1'b0}};
         trap_q      <= 1'b0;
         irom_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         inst_q      <= inst_d;
         retire_q    <= retire_d;
         trap_q      <= trap_d;
         irom_pend_q <= irom_pend_d;
      end
   end

   assign bus.irom_req = irom_req_s;
   assign bus.dram_req = dram_req_s;
   assign bus.dram_we  = dram_req_s & dec_data_we;
   assign rf_we        = ~cpu_rst & (state_q == ST_WB) & dec_rf_we;
   assign pc_we        = ~cpu_rst & (state_q == ST_WB);
   assign inst         = inst_q;
   assign trap         = trap_q;
   assign state_dbg    = state_q;
   assign retire_cnt   = retire_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed cycle-by-cycle vector bench for multicycle_sequencer, plus hand
// sequences for trap recovery and retire counter wrap.
module tb_multicycle_sequencer;

   localparam logic [31:0] ADDI = 32'h0050_0093;
   localparam logic [31:0] LW   = 32'h0000_a103;
   localparam logic [31:0] SW   = 32'h0020_a023;
   localparam logic [2:0]  S_F  = 3'd0;
   localparam logic [2:0]  S_D  = 3'd1;
   localparam logic [2:0]  S_E  = 3'd2;
   localparam logic [2:0]  S_M  = 3'd3;
   localparam logic [2:0]  S_W  = 3'd4;
   localparam logic [2:0]  S_T  = 3'd7;

   logic        cpu_clk;
   logic        cpu_rst;
   logic        halt;
   logic [31:0] inst;
   logic        dec_rf_we;
   logic        dec_data_we;
   logic        rf_we;
   logic        pc_we;
   logic        trap;
   logic [2:0]  state_dbg;
   logic [3:0]  retire_cnt;

   multicycle_sequencer_if bus_if ();

   multicycle_sequencer #(
      .TIMEOUT_CYC (4),
      .TO_W        (8),
      .RET_W       (4)
   ) dut (
      .cpu_clk     (cpu_clk),
      .cpu_rst     (cpu_rst),
      .halt        (halt),
      .bus         (bus_if),
      .inst        (inst),
      .dec_rf_we   (dec_rf_we),
      .dec_data_we (dec_data_we),
      .rf_we       (rf_we),
      .pc_we       (pc_we),
      .trap        (trap),
      .state_dbg   (state_dbg),
      .retire_cnt  (retire_cnt)
   );

   // Minimal decoder: stores write memory, everything else writes the RF.
   assign dec_data_we = (inst[6:0] == 7'b0100011);
   assign dec_rf_we   = (inst[6:0] != 7'b0100011);

   initial cpu_clk = 1'b0;
   always #5 cpu_clk = ~cpu_clk;

   typedef struct packed {
      logic [3:0]  in_ctl;   // {rst, halt, irom_ack, dram_ack}
      logic [31:0] rdata;
      logic [12:0] exp;      // {irom_req, dram_req, dram_we, rf_we, pc_we, trap, state[2:0], retire[3:0]}
   } vec_t;

   vec_t vecs[$];
   int   tests  = 0;
   int   failed = 0;

   task automatic add(input logic [3:0] ctl, input logic [31:0] rd, input logic [5:0] o,
                      input logic [2:0] st, input logic [3:0] ret);
      vec_t v;
      v.in_ctl = ctl;
      v.rdata  = rd;
      v.exp    = {o, st, ret};
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   logic [12:0] act;
   int          pulses;
   int          rf_pulses;
   int          cycles;

   initial begin
      cpu_rst = 1'b1;
      halt = 1'b0;
      bus_if.irom_ack = 1'b0;
      bus_if.dram_ack = 1'b0;
      bus_if.irom_rdata = 32'h0;

      // ADDI, zero-wait fetch: 4 cycles
      add(4'b0010, ADDI, 6'b100000, S_F, 4'd0);
      add(4'b0010, ADDI, 6'b000000, S_D, 4'd0);
      add(4'b0010, ADDI, 6'b000000, S_E, 4'd0);
      add(4'b0010, ADDI, 6'b000110, S_W, 4'd0);
      // LW with dram_ack after 3 wait cycles (ack lands on the limit cycle)
      add(4'b0010, LW, 6'b100000, S_F, 4'd1);
      add(4'b0010, LW, 6'b000000, S_D, 4'd1);
      add(4'b0010, LW, 6'b000000, S_E, 4'd1);
      for (int i = 0; i < 3; i++) add(4'b0010, LW, 6'b010000, S_M, 4'd1);
      add(4'b0011, LW, 6'b010000, S_M, 4'd1);
      add(4'b0010, LW, 6'b000110, S_W, 4'd1);
      // SW: dram_we with dram_req, pc_we only
      add(4'b0010, SW, 6'b100000, S_F, 4'd2);
      add(4'b0010, SW, 6'b000000, S_D, 4'd2);
      add(4'b0010, SW, 6'b000000, S_E, 4'd2);
      add(4'b0011, SW, 6'b011000, S_M, 4'd2);
      add(4'b0010, SW, 6'b000010, S_W, 4'd2);
      // halt before fetch for 10 cycles, stray acks ignored
      for (int i = 0; i < 10; i++) add(4'b0110, LW, 6'b000000, S_F, 4'd3);
      add(4'b0000, ADDI, 6'b100000, S_F, 4'd3);
      add(4'b0100, ADDI, 6'b100000, S_F, 4'd3);
      add(4'b0100, ADDI, 6'b100000, S_F, 4'd3);
      add(4'b0110, ADDI, 6'b100000, S_F, 4'd3);
      add(4'b0110, ADDI, 6'b000000, S_D, 4'd3);
      add(4'b0110, ADDI, 6'b000000, S_E, 4'd3);
      add(4'b0110, ADDI, 6'b000110, S_W, 4'd3);
      // reset while waiting in MEM
      add(4'b0010, LW, 6'b100000, S_F, 4'd4);
      add(4'b0010, LW, 6'b000000, S_D, 4'd4);
      add(4'b0010, LW, 6'b000000, S_E, 4'd4);
      add(4'b0010, LW, 6'b010000, S_M, 4'd4);
      add(4'b1010, LW, 6'b000000, S_M, 4'd4);
      add(4'b0100, LW, 6'b000000, S_F, 4'd0);
      // fetch timeout after 4 wait cycles, trap sticky
      for (int i = 0; i < 4; i++) add(4'b0000, LW, 6'b100000, S_F, 4'd0);
      add(4'b0000, LW, 6'b000001, S_T, 4'd0);
      add(4'b0011, ADDI, 6'b000001, S_T, 4'd0);

      @(negedge cpu_clk);
      #1;
      check("reset_outputs", {19'h0, bus_if.irom_req, bus_if.dram_req, bus_if.dram_we,
                              rf_we, pc_we, trap, state_dbg, retire_cnt}, 32'h0);
      check("reset_inst", inst, 32'h0);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge cpu_clk);
         {cpu_rst, halt, bus_if.irom_ack, bus_if.dram_ack} = vecs[i].in_ctl;
         bus_if.irom_rdata = vecs[i].rdata;
         #1;
         act = {bus_if.irom_req, bus_if.dram_req, bus_if.dram_we, rf_we, pc_we, trap,
                state_dbg, retire_cnt};
         check($sformatf("vec%0d", i), {19'h0, act}, {19'h0, vecs[i].exp});
      end

      // trap leaves only through reset
      @(negedge cpu_clk);
      cpu_rst = 1'b1;
      halt    = 1'b1;
      @(negedge cpu_clk);
      cpu_rst = 1'b0;
      #1;
      check("trap_cleared", {31'h0, trap}, 32'h0);
      check("state_after_trap_rst", {29'h0, state_dbg}, {29'h0, S_F});
      check("inst_after_rst", inst, 32'h0);

      // 17 zero-wait ADDIs with a 4-bit retire counter
      pulses    = 0;
      rf_pulses = 0;
      cycles    = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge cpu_clk);
         halt = 1'b0;
         bus_if.irom_ack = 1'b1;
         bus_if.dram_ack = 1'b0;
         bus_if.irom_rdata = ADDI;
         #1;
         cycles++;
         if (pc_we) pulses++;
         if (rf_we) rf_pulses++;
         if (pulses == 17) break;
      end
      check("pc_we_pulses", pulses, 32'd17);
      check("rf_we_pulses", rf_pulses, 32'd17);
      check("cycles_17_addi", cycles, 32'd68);
      @(negedge cpu_clk);
      #1;
      check("retire_wrap", {28'h0, retire_cnt}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
